cmd_sequencer: RTL and testbench

Generates the 8-bit Command stream that drives the accelerator's command decoder.
On a start request it issues one full pass: LOAD, CONV, WRITE, PRINT for the selected channel(s), R, L or RL, each held for a programmed number of cycles.
It then returns to END and flags completion.
It sits between the host/top-level control and the command decoder, acting as the initiator of the Command interface.

---
 rtl/cmd_sequencer.sv | 136 +++++++++++++
 tb/tb_cmd_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cmd_sequencer.sv
// cmd_sequencer: on a start request it runs one full pass of LOAD, CONV,
// WRITE and PRINT for the latched channel select. Each command is held for
// a programmed number of cycles. The sequencer then returns to END and
// pulses done for one cycle.
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   start      pass request, accepted only in IDLE with sel != 00 and hold = 0
//   sel[1:0]   channel select (01=R, 10=L, 11=RL), latched at start
//   hold       freeze state, phase counter and Command
//   Command    registered command code to the decoder
//   busy       high while a pass is in progress
//   done       one-cycle pulse when a pass completes
//   phase_cnt  0-based cycle index within the current phase
module cmd_sequencer #(
  parameter int LOAD_CYC  = 9,
  parameter int CONV_CYC  = 16,
  parameter int WRITE_CYC = 4,
  parameter int PRINT_CYC = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic             hold,
  output logic [7:0]       Command,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] phase_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CONV, S_WRITE, S_PRINT} state_e;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYC - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_CYC - 1);
  localparam logic [CNT_W-1:0] PRINT_LAST = CNT_W'(PRINT_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] last_cnt;
  logic             last;

  function automatic logic [7:0] code_of(state_e s, logic [1:0] ss);
    case (s)
      S_LOAD:  code_of = {6'b000000, ss};
      S_CONV:  code_of = {6'b000100, ss};
      S_WRITE: code_of = {6'b001000, ss};
      S_PRINT: code_of = {6'b010000, ss};
      default: code_of = 8'h80;
    endcase
  endfunction

  always_comb begin
    case (state_q)
      S_LOAD:  last_cnt = LOAD_LAST;
      S_CONV:  last_cnt = CONV_LAST;
      S_WRITE: last_cnt = WRITE_LAST;
      S_PRINT: last_cnt = PRINT_LAST;
      default: last_cnt = '0;
    endcase
  end

  assign last = (cnt_q == last_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'b00;
      cmd_q   <= 8'h80;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      cmd_q   <= cmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    if (!hold) begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (start && sel != 2'b00) begin
            state_d = S_LOAD;
            sel_d   = sel;
          end
        end
        default: begin
          if (last) begin
            cnt_d = '0;
            case (state_q)
              S_LOAD:  state_d = S_CONV;
              S_CONV:  state_d = S_WRITE;
              S_WRITE: state_d = S_PRINT;
              default: state_d = S_IDLE;
            endcase
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Output logic. The outputs are registered from the next state, so each
  // code appears in the same cycle as its state. Under hold, state_d equals
  // state_q, so Command is unchanged and done falls.
  always_comb begin
    cmd_d  = code_of(state_d, sel_d);
    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_PRINT) && (state_d == S_IDLE);
  end

  assign Command   = cmd_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign phase_cnt = cnt_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
module tb_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, hold;
  logic [1:0] sel;
  logic [7:0] Command;
  logic       busy, done;
  logic [7:0] phase_cnt;

  cmd_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .sel(sel), .hold(hold),
    .Command(Command), .busy(busy), .done(done), .phase_cnt(phase_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0][7:0]  code;
    logic [3:0][15:0] len;
    logic [15:0]      busy_len;
  } pass_t;

  pass_t exp_q[$];
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected pass, with codes and lengths derived by hand from the default parameters.
  function automatic pass_t mk_pass(input logic [1:0] s, input int conv_len);
    pass_t p;
    p.code[0] = {6'b000000, s}; p.len[0] = 16'd9;
    p.code[1] = {6'b000100, s}; p.len[1] = 16'(conv_len);
    p.code[2] = {6'b001000, s}; p.len[2] = 16'd4;
    p.code[3] = {6'b010000, s}; p.len[3] = 16'd4;
    p.busy_len = 16'(9 + conv_len + 4 + 4);
    return p;
  endfunction

  task automatic pulse(input logic [1:0] s);
    start = 1'b1; sel = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      @(negedge clk);
      if (done === 1'b1) found = 1;
    end
    chk(name, found, 1);
  endtask

  task automatic wait_cmd(input string name, input logic [7:0] c, input int cnt);
    int found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      if (Command === c && (cnt < 0 || int'(phase_cnt) == cnt)) found = 1;
      else @(negedge clk);
    end
    chk(name, found, 1);
  endtask

  initial begin
    logic [7:0] run_code [8];
    int         run_len  [8];
    int         run_n    = 0;
    int         busy_cnt = 0;
    logic       prev_done = 1'b0;
    pass_t      e;

    reset = 1'b0; start = 1'b0; hold = 1'b0; sel = 2'b00;

    // Monitor: rebuilds each pass as runs of codes and checks it on done.
    fork
      forever begin
        @(negedge clk);
        if (busy === 1'b1) begin
          if (run_n > 0 && run_n <= 8 && Command == run_code[run_n-1])
            run_len[run_n-1]++;
          else begin
            if (run_n < 8) begin
              run_code[run_n] = Command;
              run_len[run_n]  = 1;
            end
            run_n++;
          end
          busy_cnt++;
        end
        if (done === 1'b1) begin
          chk("done_cmd", Command, 8'h80);
          chk("done_busy", busy, 0);
          chk("done_width", prev_done, 0);
          chk("exp_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("run_count", run_n, 4);
            for (int i = 0; i < 4 && i < run_n; i++) begin
              chk($sformatf("code%0d", i), run_code[i], e.code[i]);
              chk($sformatf("len%0d", i), run_len[i], e.len[i]);
            end
            chk("busy_len", busy_cnt, e.busy_len);
          end
          run_n = 0; busy_cnt = 0;
        end else if (busy !== 1'b1) begin
          run_n = 0; busy_cnt = 0;
        end
        prev_done = (done === 1'b1);
      end
    join_none

    // Reset, then idle
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("rst_cmd", Command, 8'h80);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", phase_cnt, 0);
    repeat (3) @(negedge clk);
    chk("idle_cmd", Command, 8'h80);
    chk("idle_busy", busy, 0);

    // Full RL pass
    exp_q.push_back(mk_pass(2'b11, 16));
    pulse(2'b11);
    chk("load_first", Command, 8'h03);
    chk("load_cnt0", phase_cnt, 0);
    wait_done("wait_rl");

    // R pass, then L started on the edge where done is visible
    exp_q.push_back(mk_pass(2'b01, 16));
    pulse(2'b01);
    wait_done("wait_r");
    exp_q.push_back(mk_pass(2'b10, 16));
    pulse(2'b10);
    wait_done("wait_l");

    // Invalid select and hold in IDLE both block start
    pulse(2'b00);
    repeat (3) @(negedge clk);
    chk("sel00_busy", busy, 0);
    chk("sel00_cmd", Command, 8'h80);
    hold = 1'b1;
    pulse(2'b01);
    chk("idlehold_busy", busy, 0);
    chk("idlehold_cmd", Command, 8'h80);
    hold = 1'b0;
    @(negedge clk);

    // Hold for 5 cycles at CONV phase_cnt=7
    exp_q.push_back(mk_pass(2'b11, 21));
    pulse(2'b11);
    wait_cmd("wait_conv7", 8'h13, 7);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_cmd", Command, 8'h13);
      chk("hold_cnt", phase_cnt, 7);
    end
    hold = 1'b0;
    wait_done("wait_hold");

    // Start and sel change during the pass are ignored
    exp_q.push_back(mk_pass(2'b11, 16));
    pulse(2'b11);
    wait_cmd("wait_conv", 8'h13, -1);
    pulse(2'b01);
    wait_done("wait_busystart");
    repeat (4) @(negedge clk);
    chk("no_restart_busy", busy, 0);

    // Reset mid-WRITE aborts without done; the next pass is clean
    pulse(2'b11);
    wait_cmd("wait_write", 8'h23, -1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_cmd", Command, 8'h80);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", phase_cnt, 0);
    chk("abort_done", done, 0);
    reset = 1'b1;
    exp_q.push_back(mk_pass(2'b11, 16));
    pulse(2'b11);
    wait_done("wait_after_abort");

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
